// File: rtl/note_chart_buffer_if.sv
// Host write stream plus the timed note readout handshake of note_chart_buffer.
interface note_chart_buffer_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LOGSIZE = 12
);
  logic               write_en;
  logic [WIDTH-1:0]   write_word;
  logic               note_valid;
  logic               note_ready;
  logic [WIDTH-1:0]   note_word;
  logic [LOGSIZE-1:0] note_index;

  modport master (
    output write_en, write_word, note_ready,
    input  note_valid, note_word, note_index
  );

  modport slave (
    input  write_en, write_word, note_ready,
    output note_valid, note_word, note_index
  );
endinterface

// File: rtl/note_chart_buffer.sv
// Note-chart store: loads host note words until an end marker or full, then
// replays them in order, releasing each once song_time + LOOKAHEAD reaches it.
module note_chart_buffer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOGSIZE   = 12,
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned LOOKAHEAD = 1000
) (
  input  logic                clk,
  input  logic                reset,
  note_chart_buffer_if.slave  bus,
  input  logic                clear,
  input  logic                play_start,
  input  logic [TIME_W-1:0]   song_time,
  output logic                loaded,
  output logic                overflow,
  output logic [LOGSIZE:0]    note_count,
  output logic                song_done
);

  localparam int unsigned DEPTH = 2 ** LOGSIZE;
  localparam int unsigned CNT_W = LOGSIZE + 1;

  typedef enum logic [2:0] {
    S_LOAD, S_ARMED, S_FETCH, S_WAIT, S_CHECK, S_EMIT, S_DONE
  } state_t;

  state_t             state;
  logic [LOGSIZE-1:0] wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   ram_q;
  logic [LOGSIZE-1:0] ram_addr;
  logic               ram_we;
  logic               is_marker;

  logic [TIME_W:0]    time_sum;
  logic [TIME_W-1:0]  threshold;
  logic [TIME_W-1:0]  note_time;

  assign is_marker = (bus.write_word[WIDTH-1 -: 3] == 3'b111);
  assign note_time = bus.note_word[TIME_W-1:0];

  // Saturating release threshold: a note near the top of the time range must still go out.
  assign time_sum  = {1'b0, song_time} + (TIME_W+1)'(LOOKAHEAD);
  assign threshold = time_sum[TIME_W] ? '1 : time_sum[TIME_W-1:0];

  // Single RAM port: write pointer while loading, read pointer otherwise.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = rd_ptr[LOGSIZE-1:0];
    if (state == S_LOAD) begin
      ram_addr = wr_ptr;
      ram_we   = bus.write_en && !is_marker && !reset && !clear;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= bus.write_word;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_LOAD;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      note_count     <= '0;
      loaded         <= 1'b0;
      overflow       <= 1'b0;
      song_done      <= 1'b0;
      bus.note_valid <= 1'b0;
      bus.note_word  <= '0;
      bus.note_index <= '0;
    end else if (clear) begin
      state          <= S_LOAD;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      note_count     <= '0;
      loaded         <= 1'b0;
      overflow       <= 1'b0;
      song_done      <= 1'b0;
      bus.note_valid <= 1'b0;
    end else if (play_start && state != S_LOAD) begin
      // Restart from note 0; a handshake in this same cycle is dropped.
      rd_ptr         <= '0;
      song_done      <= 1'b0;
      bus.note_valid <= 1'b0;
      state          <= S_FETCH;
    end else begin
      case (state)
        S_LOAD: begin
          if (bus.write_en) begin
            if (is_marker) begin
              note_count <= {1'b0, wr_ptr};
              loaded     <= 1'b1;
              state      <= S_ARMED;
            end else begin
              wr_ptr <= wr_ptr + LOGSIZE'(1);
              if (wr_ptr == LOGSIZE'(DEPTH - 1)) begin
                note_count <= CNT_W'(DEPTH);
                overflow   <= 1'b1;
                loaded     <= 1'b1;
                state      <= S_ARMED;
              end
            end
          end
        end
        S_FETCH: begin
          if (rd_ptr == note_count) begin
            song_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          bus.note_word <= ram_q;
          state         <= S_CHECK;
        end
        S_CHECK: begin
          if (note_time <= threshold) begin
            bus.note_valid <= 1'b1;
            bus.note_index <= rd_ptr[LOGSIZE-1:0];
            state          <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.note_ready) begin
            bus.note_valid <= 1'b0;
            rd_ptr         <= rd_ptr + CNT_W'(1);
            state          <= S_FETCH;
          end
        end
        S_ARMED, S_DONE: ;
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
